// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO register pair and its iterative divider.
package hilo_pkg;

  localparam int unsigned ITER_CNT_W = 6;
  localparam logic [31:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } hilo_state_e;

  // Two's-complement negate when cond is set.
  function automatic logic [31:0] neg_if(input logic cond, input logic [31:0] x);
    return cond ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/hilo_div_unit_div_core.sv
// Restoring radix-2 unsigned divider: one quotient bit per cycle on a 64-bit {rem, quo} register.
module div_core
  import hilo_pkg::*;
#(
  parameter int unsigned DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        kill_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o,
  output logic        valid_o,
  output logic        last_c
);

  localparam logic [ITER_CNT_W-1:0] LAST_CNT = ITER_CNT_W'(DIV_ITERS);
  localparam logic [ITER_CNT_W-1:0] PRE_LAST_CNT = ITER_CNT_W'(DIV_ITERS - 1);

  logic [63:0]           rq_q, rq_d;
  logic [31:0]           b_q, b_d;
  logic [ITER_CNT_W-1:0] cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic [32:0]           part;
  logic [32:0]           diff;
  logic                  ge;

  // Partial remainder is 33 bits wide after the shift; the borrow decides the quotient bit.
  always_comb begin
    part = rq_q[63:31];
    diff = part - {1'b0, b_q};
    ge   = ~diff[32];
  end

  always_comb begin
    rq_d   = rq_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (kill_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start_i) begin
      rq_d   = {32'd0, a_i};
      b_d    = b_i;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == LAST_CNT) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        rq_d  = ge ? {diff[31:0], rq_q[30:0], 1'b1} : {rq_q[62:0], 1'b0};
        cnt_d = cnt_q + ITER_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rq_q   <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rq_q   <= rq_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign quo_o   = rq_q[31:0];
  assign rem_o   = rq_q[63:32];
  assign valid_o = busy_q & (cnt_q == LAST_CNT);
  assign last_c  = busy_q & (cnt_q == PRE_LAST_CNT);

endmodule

// File: rtl/hilo_div_unit.sv
// HI/LO architectural registers with DIV/DIVU sequencing, sign fix-up and pipeline stall.
module hilo_div_unit
  import hilo_pkg::*;
#(
  parameter int unsigned DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hi_wdata,
  input  logic [31:0] lo_wdata,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic [31:0] div_a,
  input  logic [31:0] div_b,
  input  logic        flush,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stall_o,
  output logic        div_busy,
  output logic        div_done
);

  hilo_state_e state_q, state_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        dbz_q, dbz_d;
  logic [31:0] a_raw_q, a_raw_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        accept_c;
  logic [31:0] a_mag, b_mag;
  logic [31:0] core_quo, core_rem;
  logic        core_valid, core_last;

  assign accept_c = (state_q == IDLE) & div_start & ~flush;
  assign a_mag    = neg_if(div_signed & div_a[31], div_a);
  assign b_mag    = neg_if(div_signed & div_b[31], div_b);

  div_core #(
    .DIV_ITERS(DIV_ITERS)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .start_i(accept_c),
    .kill_i (flush),
    .a_i    (a_mag),
    .b_i    (b_mag),
    .quo_o  (core_quo),
    .rem_o  (core_rem),
    .valid_o(core_valid),
    .last_c (core_last)
  );

  always_comb begin
    state_d  = state_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    dbz_d    = dbz_q;
    a_raw_d  = a_raw_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    stall_o  = 1'b0;
    div_busy = 1'b0;
    div_done = 1'b0;

    unique case (state_q)
      IDLE:    if (accept_c) state_d = DIV;
      DIV:     if (core_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;

    if (accept_c) begin
      q_neg_d = div_signed & (div_a[31] ^ div_b[31]);
      r_neg_d = div_signed & div_a[31];
      dbz_d   = (div_b == 32'd0);
      a_raw_d = div_a;
    end

    stall_o  = accept_c | (state_q == DIV);
    div_busy = (state_q != IDLE);
    div_done = (state_q == DONE) & ~flush;

    // Write-back is older, so a completing divide overrides it in the same cycle.
    if (hi_we) hi_d = hi_wdata;
    if (lo_we) lo_d = lo_wdata;
    if (div_done & core_valid) begin
      hi_d = dbz_q ? a_raw_q : neg_if(r_neg_q, core_rem);
      lo_d = dbz_q ? DIV_BY_ZERO_LO : neg_if(q_neg_q, core_quo);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dbz_q   <= 1'b0;
      a_raw_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dbz_q   <= dbz_d;
      a_raw_q <= a_raw_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Bench for hilo_div_unit: arithmetic reference model compared every cycle, plus literal directed checks.
module tb_hilo_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic [31:0] hi_wdata = '0, lo_wdata = '0;
  logic        div_start = 1'b0, div_signed = 1'b0;
  logic [31:0] div_a = '0, div_b = '0;
  logic        flush = 1'b0;
  logic [31:0] hi_o, lo_o;
  logic        stall_o, div_busy, div_done;

  int chk_cnt = 0;
  int pass_cnt = 0;

  hilo_div_unit #(.DIV_ITERS(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .hi_wdata  (hi_wdata),
    .lo_wdata  (lo_wdata),
    .div_start (div_start),
    .div_signed(div_signed),
    .div_a     (div_a),
    .div_b     (div_b),
    .flush     (flush),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .stall_o   (stall_o),
    .div_busy  (div_busy),
    .div_done  (div_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference result {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Model: m_k counts cycles since acceptance (0 = no divide in flight, 33 = result cycle).
  int          m_k = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_res = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_hi <= '0;
      m_lo <= '0;
      m_k  <= 0;
    end else begin
      if (hi_we) m_hi <= hi_wdata;
      if (lo_we) m_lo <= lo_wdata;
      if (m_k == 33 && !flush) begin
        m_hi <= m_res[63:32];
        m_lo <= m_res[31:0];
      end
      if (flush) m_k <= 0;
      else if (m_k == 0) begin
        if (div_start) begin
          m_k   <= 1;
          m_res <= ref_div(div_signed, div_a, div_b);
        end
      end else if (m_k == 33) m_k <= 0;
      else m_k <= m_k + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("hi_o", hi_o, m_hi);
      check("lo_o", lo_o, m_lo);
      check("stall_o", 32'(stall_o),
            32'((m_k == 0 && div_start && !flush) || (m_k >= 1 && m_k <= 32)));
      check("div_busy", 32'(div_busy), 32'(m_k != 0));
      check("div_done", 32'(div_done), 32'(m_k == 33 && !flush));
    end
  end

  task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] elo, input logic [31:0] ehi, input bit wb);
    int stalls = 0;
    int done_at = -1;
    @(posedge clk); #1;
    div_start = 1'b1; div_signed = sg; div_a = a; div_b = b;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (stall_o) stalls++;
      if (div_done) begin
        done_at = c;
        if (wb) begin
          hi_we = 1'b1; lo_we = 1'b1;
          hi_wdata = 32'hAAAA_AAAA; lo_wdata = 32'hAAAA_AAAA;
        end
        break;
      end
    end
    check("done_cycle", 32'(done_at), 32'd33);
    check("stall_cycles", 32'(stalls), 32'd33);
    @(posedge clk); #1;
    div_start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    @(negedge clk);
    check("lit_lo", lo_o, elo);
    check("lit_hi", hi_o, ehi);
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(4))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_hi", hi_o, 32'd0);
    check("rst_lo", lo_o, 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_busy", 32'(div_busy), 32'd0);
    check("rst_done", 32'(div_done), 32'd0);

    // Write-back path.
    @(posedge clk); #1;
    hi_we = 1'b1; lo_we = 1'b1; hi_wdata = 32'h1234_5678; lo_wdata = 32'h9ABC_DEF0;
    @(negedge clk);
    check("wb_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    @(negedge clk);
    check("wb_hi", hi_o, 32'h1234_5678);
    check("wb_lo", lo_o, 32'h9ABC_DEF0);

    run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    run_div(1'b0, 32'h55, 32'd0, 32'hFFFF_FFFF, 32'h55, 1'b0);

    // Flush in the middle of a divide.
    @(posedge clk); #1;
    div_start = 1'b1; div_signed = 1'b0; div_a = 32'd9; div_b = 32'd3;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; div_start = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(div_busy), 32'd0);
    check("flush_hi", hi_o, 32'h55);
    check("flush_lo", lo_o, 32'hFFFF_FFFF);
    repeat (40) @(negedge clk);
    check("flush_hi_later", hi_o, 32'h55);

    run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    run_div(1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 1'b1);

    // Random traffic; divide operands held while the model says the request is stalled or retiring.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (!(m_k >= 1 && m_k <= 33)) begin
        div_start  = ($urandom_range(3) == 0);
        div_signed = 1'($urandom_range(1));
        div_a      = rand_op();
        div_b      = rand_op();
      end
      hi_we    = ($urandom_range(7) == 0);
      lo_we    = ($urandom_range(7) == 0);
      hi_wdata = $urandom;
      lo_wdata = $urandom;
      flush    = ($urandom_range(99) == 0);
    end
    @(posedge clk); #1;
    div_start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; flush = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/hilo_div_unit.md
# hilo_div_unit

HI/LO architectural register pair plus iterative 32-bit divider for the MIPS core. It is the consumer of the ALU's `hi_alu_out`/`lo_alu_out` results (MULT/MULTU/MTHI/MTLO) and the producer of the ALU's `hi_in`/`lo_in` operands (MFHI/MFLO). DIV/DIVU execute here over multiple cycles. The unit stalls the pipeline while a divide is in flight and writes the quotient to LO and the remainder to HI.

## Interface
Parameters:
- `DIV_ITERS`, 32: radix-2 iterations per divide. Fixed at 32; exists only for sim speed-up in unit benches.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `hi_we` in 1: write HI from write-back (MULT/MULTU/MTHI).
- `lo_we` in 1: write LO from write-back (MULT/MULTU/MTLO).
- `hi_wdata` in 32: HI write data (ALU `hi_alu_out`).
- `lo_wdata` in 32: LO write data (ALU `lo_alu_out`).
- `div_start` in 1: EX-stage DIV/DIVU request; held stable by the pipeline while `stall_o`=1.
- `div_signed` in 1: 1 = DIV, 0 = DIVU; sampled with `div_start`.
- `div_a` in 32: dividend (rs).
- `div_b` in 32: divisor (rt).
- `flush` in 1: exception/eret flush; cancels any in-flight divide.
- `hi_o` out 32: registered HI, feeds ALU `hi_in`.
- `lo_o` out 32: registered LO, feeds ALU `lo_in`.
- `stall_o` out 1: hold IF..EX.
- `div_busy` out 1: state ≠ IDLE.
- `div_done` out 1: one-cycle pulse in DONE.

## Operation
- State machine: IDLE, DIV, DONE.
  - IDLE→DIV when `div_start & !flush`. Operands are latched on that edge.
  - DIV→DONE after `DIV_ITERS` cycles.
  - DONE→IDLE unconditionally.
  - Any state→IDLE on `flush`.
- The operand-latch edge also captures the sign controls:
  - quotient sign = `a[31]^b[31]`;
  - remainder sign = `a[31]`, signed only;
  - magnitudes via two's-complement negate when signed and negative.
- Core: restoring shift-subtract on a 64-bit {rem, quo} register with a 6-bit iteration counter.
- Final fix-up in DONE:
  - LO = quotient, negated if the quotient sign is set;
  - HI = remainder, negated if the remainder sign is set.
- Signed 0x80000000 / 0xFFFFFFFF produces LO=0x80000000, HI=0. This falls out naturally and needs no special case.
- Divide by zero (`div_b`=0): result LO=0xFFFFFFFF, HI=`div_a`. The FSM still runs the full latency, so latency is deterministic.
- HI/LO write priority:
  - DONE result beats `hi_we`/`lo_we` in the same cycle, because the divide is the younger instruction;
  - otherwise HI and LO are written independently per their enables.
- `div_start` while not IDLE is ignored.
- `div_start` in the DONE cycle is not re-accepted. The pipeline has advanced, so a new request arrives next cycle.
- `flush` while in DIV or DONE: no HI/LO update, `div_done` stays 0, IDLE next cycle.
- `flush` together with a write-back write: the write-back write still commits, because the write-back stage is older than the flush point.
- No read bypass: `hi_o`/`lo_o` reflect registered values only. Forwarding is the hazard unit's job.

## Timing
- Reset values:
  - `hi_o`=0, `lo_o`=0;
  - state IDLE;
  - `stall_o`=0, `div_busy`=0, `div_done`=0;
  - counter 0.
- `stall_o` = `(IDLE & div_start & !flush) | DIV`. It is combinational on `div_start`, and 0 in DONE so EX retires in the DONE cycle.
- Cycle numbering, with `div_start` seen in IDLE at cycle 0:
  - cycles 1–32: DIV;
  - cycle 33: DONE, `div_done`=1;
  - cycle 34: new `hi_o`/`lo_o` visible.
- `stall_o` is high for cycles 0–32 (33 cycles).
- Write-back HI/LO writes: the value is visible on `hi_o`/`lo_o` the cycle after the enable.

## Structure
- Shared package `hilo_pkg`:
  - state enum `{IDLE, DIV, DONE}`;
  - `DIV_BY_ZERO_LO` = 32'hFFFF_FFFF;
  - iteration-count width constant.
- Sub-module `div_core`: 32-iteration restoring unsigned divider.
  - Inputs: start, a, b, kill.
  - Outputs: quo, rem, valid.
- The top level holds the FSM, the sign handling, and the HI/LO registers.

## Test plan
- Reset, then `hi_we`=`lo_we`=1 with 0x12345678/0x9ABCDEF0 → `hi_o`/`lo_o` equal those values one cycle later; `stall_o` stays 0.
- DIVU 100 / 7 → `stall_o` high 33 cycles, `div_done` at cycle 33, cycle 34 LO=14 and HI=2.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 0x55 / 0 → same 33-cycle latency, LO=0xFFFFFFFF, HI=0x55.
- Start DIVU 9/3, assert `flush` at cycle 10 → `div_done` never pulses, HI/LO unchanged, IDLE at cycle 11. A new DIVU 9/3 then gives LO=3, HI=0.
- In the DONE cycle of DIVU 20/6, also pulse `hi_we`=`lo_we`=1 with 0xAAAA_AAAA → next cycle LO=3, HI=2 (divide wins).
